// File: rtl/acc_axi_pkg.sv
// Shared AXI constants, FSM state type and small helpers for the accelerator's AXI masters.
package acc_axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int unsigned AXI_4K_BYTES = 4096;

    typedef enum logic [1:0] {
        RM_IDLE,
        RM_ISSUE,
        RM_DRAIN
    } rmst_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Beats that fit before the next 4 KB page; addr is the beat-aligned page offset.
    function automatic logic [12:0] beats_to_4k(input logic [11:0] addr, input int unsigned beat_bytes);
        return 13'((AXI_4K_BYTES - {20'd0, addr}) / beat_bytes);
    endfunction

endpackage

// File: rtl/burst_splitter.sv
// Picks the length of the next AXI burst: the smallest of what is left, the burst cap and the 4 KB page limit.
module burst_splitter
    import acc_axi_pkg::*;
#(
    parameter int DATA_WIDTH_BYTE = 64,
    parameter int BURST_LENGTH = 64,
    parameter int CNT_WIDTH = 58
) (
    input  logic [CNT_WIDTH-1:0] remaining,
    input  logic [11:0]          addr_lo,
    output logic [8:0]           burst_beats
);

    logic [12:0] lim_4k;
    logic [12:0] cap;

    always_comb begin
        lim_4k = beats_to_4k(addr_lo, DATA_WIDTH_BYTE);
        cap = (lim_4k < 13'(BURST_LENGTH)) ? lim_4k : 13'(BURST_LENGTH);
        burst_beats = (remaining < CNT_WIDTH'(cap)) ? 9'(remaining) : 9'(cap);
    end

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read master: splits one byte-range request into 4 KB-safe INCR bursts and streams the R beats
// straight through to the conv input buffer.
module axi_read_master
    import acc_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int DATA_WIDTH_BYTE = DATA_WIDTH / 8,
    parameter int BURST_LENGTH = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rmst_req,
    input  logic [63:0]           addr_offset,
    input  logic [63:0]           xfer_size,
    output logic                  rmst_done,
    output logic                  busy,
    output logic                  err,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rlast,
    input  logic [1:0]            m_axi_rresp,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    input  logic                  tready
);

    localparam int OFF_BITS = clog2(DATA_WIDTH_BYTE);
    localparam int CNT_WIDTH = ADDR_WIDTH - OFF_BITS;
    localparam int OUT_WIDTH = clog2(MAX_OUTSTANDING + 1);

    if (BURST_LENGTH < 1 || BURST_LENGTH > 256) begin : g_bad_burst_length
        $error("axi_read_master: BURST_LENGTH must be within 1..256");
    end

    rmst_state_t           state_q;
    rmst_state_t           state_d;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic [OUT_WIDTH-1:0]  outstanding_q;
    logic                  zero_done_q;
    logic                  err_q;

    logic [64:0]           beat_sum;
    logic [CNT_WIDTH-1:0]  req_beats;
    logic [8:0]            burst_beats;
    logic                  ar_valid;
    logic                  take_req;
    logic                  drain_done;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  last_hs;

    // The misaligned head of the first beat counts towards the beat total.
    assign beat_sum  = {1'b0, xfer_size} + 65'(addr_offset[OFF_BITS-1:0]) + 65'(DATA_WIDTH_BYTE - 1);
    assign req_beats = CNT_WIDTH'(beat_sum >> OFF_BITS);

    burst_splitter #(
        .DATA_WIDTH_BYTE (DATA_WIDTH_BYTE),
        .BURST_LENGTH    (BURST_LENGTH),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_burst_splitter (
        .remaining   (remaining_q),
        .addr_lo     (araddr_q[11:0]),
        .burst_beats (burst_beats)
    );

    assign ar_hs   = ar_valid & m_axi_arready;
    assign r_hs    = m_axi_rvalid & m_axi_rready;
    assign last_hs = r_hs & m_axi_rlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero-length done pulse blocks a new request so done never coincides with a request being taken.
    always_comb begin
        state_d    = state_q;
        ar_valid   = 1'b0;
        take_req   = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            RM_IDLE: begin
                if (rmst_req && !zero_done_q) begin
                    take_req = 1'b1;
                    if (req_beats != '0) begin
                        state_d = RM_ISSUE;
                    end
                end
            end
            RM_ISSUE: begin
                ar_valid = outstanding_q < OUT_WIDTH'(MAX_OUTSTANDING);
                if (ar_valid && m_axi_arready && remaining_q == CNT_WIDTH'(burst_beats)) begin
                    state_d = RM_DRAIN;
                end
            end
            RM_DRAIN: begin
                if (outstanding_q == '0) begin
                    drain_done = 1'b1;
                    state_d    = RM_IDLE;
                end
            end
            default: state_d = RM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            araddr_q      <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            zero_done_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            zero_done_q <= take_req && (req_beats == '0);
            if (take_req) begin
                araddr_q    <= ADDR_WIDTH'(addr_offset & ~64'(DATA_WIDTH_BYTE - 1));
                remaining_q <= req_beats;
            end else if (ar_hs) begin
                araddr_q    <= araddr_q + (ADDR_WIDTH'(burst_beats) << OFF_BITS);
                remaining_q <= remaining_q - CNT_WIDTH'(burst_beats);
            end
            if (ar_hs && !last_hs) begin
                outstanding_q <= outstanding_q + OUT_WIDTH'(1);
            end else if (!ar_hs && last_hs) begin
                outstanding_q <= outstanding_q - OUT_WIDTH'(1);
            end
            if (r_hs && m_axi_rresp != RESP_OKAY) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy          = state_q != RM_IDLE;
    assign rmst_done     = zero_done_q | drain_done;
    assign err           = err_q;
    assign m_axi_arvalid = ar_valid;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = (state_q == RM_ISSUE) ? 8'(burst_beats - 9'd1) : 8'd0;
    assign m_axi_arsize  = 3'(OFF_BITS);
    assign m_axi_arburst = BURST_INCR;
    assign tdata         = m_axi_rdata;
    assign tvalid        = m_axi_rvalid & busy;
    assign m_axi_rready  = tready & busy;

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: an in-order AXI slave model plus AR/beat scoreboards filled at request time.
module tb_axi_read_master;
    import acc_axi_pkg::*;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int DB = 64;
    localparam int BL = 64;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rmst_req;
    logic [63:0]   addr_offset;
    logic [63:0]   xfer_size;
    logic          rmst_done;
    logic          busy;
    logic          err;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;
    logic [DW-1:0] m_axi_rdata = '0;
    logic          m_axi_rlast = 1'b0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b1;

    always #5 clk = ~clk;

    axi_read_master #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BURST_LENGTH    (BL),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rmst_req      (rmst_req),
        .addr_offset   (addr_offset),
        .xfer_size     (xfer_size),
        .rmst_done     (rmst_done),
        .busy          (busy),
        .err           (err),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rresp   (m_axi_rresp),
        .tdata         (tdata),
        .tvalid        (tvalid),
        .tready        (tready)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t           exp_ar_q[$];
    logic [DW-1:0] exp_beat_q[$];
    ar_t           slv_q[$];
    ar_t           ar_exp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pending = 0;
    int zero_pending = 0;
    int req_cyc = 0;
    int last_t_cyc = 0;
    int first_rlast_cyc = -1;
    int ar_count = 0;
    int done_count = 0;
    int target_ar = -1;
    int target_ar_cyc = -1;
    int slv_beat = 0;
    int slv_total = 0;
    int bad_beat = -1;

    logic arready_en = 1'b1;
    logic rvalid_en = 1'b1;
    logic tready_mode = 1'b0;
    logic mirror_en = 1'b0;
    logic rst_s = 1'b0;
    logic ar_fire_n = 1'b0;
    logic r_fire_n = 1'b0;
    logic [63:0] araddr_s = '0;
    logic [7:0]  arlen_s = '0;

    function automatic logic [DW-1:0] beatData(input logic [63:0] a);
        return {~a, 384'h0, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Sampled mid-cycle: these values are exactly what the DUT sees at the next rising edge.
    always @(negedge clk) begin
        rst_s     = rst;
        ar_fire_n = !rst && m_axi_arvalid && m_axi_arready;
        r_fire_n  = !rst && m_axi_rvalid && m_axi_rready;
        araddr_s  = m_axi_araddr;
        arlen_s   = m_axi_arlen;
        if (!rst) begin
            if (ar_fire_n) begin
                ar_count++;
                if (ar_count == target_ar) target_ar_cyc = cyc;
                checkOutput("ar_expected", DW'(exp_ar_q.size() != 0), DW'(1));
                if (exp_ar_q.size() != 0) begin
                    ar_exp = exp_ar_q.pop_front();
                    checkOutput("araddr", DW'(m_axi_araddr), DW'(ar_exp.addr));
                    checkOutput("arlen", DW'(m_axi_arlen), DW'(ar_exp.len));
                end
            end
            if (tvalid && tready) begin
                last_t_cyc = cyc;
                if (m_axi_rlast && first_rlast_cyc < 0) first_rlast_cyc = cyc;
                checkOutput("beat_expected", DW'(exp_beat_q.size() != 0), DW'(1));
                if (exp_beat_q.size() != 0) checkOutput("tdata", tdata, exp_beat_q.pop_front());
            end
            if (mirror_en && pending > 0) checkOutput("rready_mirror", DW'(m_axi_rready), DW'(tready));
            if (rmst_done) begin
                done_count++;
                checkOutput("done_expected", DW'(pending > 0), DW'(1));
                checkOutput("done_all_beats", DW'(exp_beat_q.size()), DW'(0));
                if (zero_pending != 0) begin
                    checkOutput("done_zero_timing", DW'(cyc), DW'(req_cyc + 1));
                    zero_pending = 0;
                end else begin
                    checkOutput("done_timing", DW'(cyc), DW'(last_t_cyc + 1));
                end
                if (pending > 0) pending--;
            end
        end
    end

    // In-order AXI slave: one R beat per cycle while enabled, data derived from the beat address.
    always @(posedge clk) begin
        #1;
        if (rst_s) begin
            slv_q.delete();
            slv_beat = 0;
        end else begin
            if (ar_fire_n) slv_q.push_back('{addr: araddr_s, len: arlen_s});
            if (r_fire_n && slv_q.size() != 0) begin
                slv_total++;
                if (slv_beat == int'(slv_q[0].len)) begin
                    void'(slv_q.pop_front());
                    slv_beat = 0;
                end else begin
                    slv_beat++;
                end
            end
        end
        m_axi_arready = arready_en;
        if (rvalid_en && slv_q.size() != 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beatData(slv_q[0].addr + 64'(slv_beat) * 64'(DB));
            m_axi_rlast  = (slv_beat == int'(slv_q[0].len));
            m_axi_rresp  = (slv_total == bad_beat) ? 2'b10 : RESP_OKAY;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = RESP_OKAY;
        end
        tready = tready_mode ? !tready : 1'b1;
    end

    // Builds the expected AR list and beat stream for the request, then pulses rmst_req for one cycle.
    task automatic applyStimulus(input logic [63:0] off, input logic [63:0] size);
        logic [63:0] a;
        logic [63:0] beats;
        logic [63:0] n;
        logic [63:0] lim;
        a = off & ~64'(DB - 1);
        beats = (size + (off % 64'(DB)) + 64'(DB - 1)) / 64'(DB);
        if (beats == 0) begin
            zero_pending = 1;
            req_cyc = cyc;
        end
        while (beats != 0) begin
            lim = (64'd4096 - (a % 64'd4096)) / 64'(DB);
            n = beats;
            if (n > 64'(BL)) n = 64'(BL);
            if (n > lim) n = lim;
            exp_ar_q.push_back('{addr: a, len: 8'(n - 1)});
            for (int k = 0; k < int'(n); k++) exp_beat_q.push_back(beatData(a + 64'(k) * 64'(DB)));
            a = a + n * 64'(DB);
            beats = beats - n;
        end
        rmst_req = 1'b1;
        addr_offset = off;
        xfer_size = size;
        @(posedge clk);
        #1;
        rmst_req = 1'b0;
        pending++;
    endtask

    task automatic pulseIgnored(input logic [63:0] off, input logic [63:0] size);
        rmst_req = 1'b1;
        addr_offset = off;
        xfer_size = size;
        @(posedge clk);
        #1;
        rmst_req = 1'b0;
    endtask

    task automatic flushScoreboard();
        exp_ar_q.delete();
        exp_beat_q.delete();
        pending = 0;
        zero_pending = 0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        for (int n = 0; n < budget && pending > 0; n++) @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_complete"}, DW'(pending), DW'(0));
        checkOutput({tag, "_busy_low"}, DW'(busy), DW'(0));
        if (pending != 0) flushScoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_done"}, DW'(rmst_done), DW'(0));
        checkOutput({tag, "_busy"}, DW'(busy), DW'(0));
        checkOutput({tag, "_err"}, DW'(err), DW'(0));
        checkOutput({tag, "_arvalid"}, DW'(m_axi_arvalid), DW'(0));
        checkOutput({tag, "_araddr"}, DW'(m_axi_araddr), DW'(0));
        checkOutput({tag, "_arlen"}, DW'(m_axi_arlen), DW'(0));
        checkOutput({tag, "_arsize"}, DW'(m_axi_arsize), DW'(6));
        checkOutput({tag, "_arburst"}, DW'(m_axi_arburst), DW'(1));
        checkOutput({tag, "_rready"}, DW'(m_axi_rready), DW'(0));
        checkOutput({tag, "_tvalid"}, DW'(tvalid), DW'(0));
        checkOutput({tag, "_tdata"}, tdata, DW'(0));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int ar_base;
        int done_base;
        rst = 1'b1;
        rmst_req = 1'b0;
        addr_offset = '0;
        xfer_size = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkQuiet("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single page-aligned 4 KB burst.
        ar_base = ar_count;
        applyStimulus(64'h1000, 64'd4096);
        waitIdle("full_page", 300);
        checkOutput("full_page_ar_count", DW'(ar_count - ar_base), DW'(1));

        // Request straddling a 4 KB boundary splits into two bursts.
        ar_base = ar_count;
        applyStimulus(64'h1F80, 64'd256);
        waitIdle("cross_4k", 100);
        checkOutput("cross_4k_ar_count", DW'(ar_count - ar_base), DW'(2));

        // Outstanding limit: no R data, so AR issue stalls at MO bursts.
        ar_base = ar_count;
        rvalid_en = 1'b0;
        first_rlast_cyc = -1;
        applyStimulus(64'h0, 64'd32768);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("outstanding_ar_count", DW'(ar_count - ar_base), DW'(MO));
        checkOutput("outstanding_arvalid_low", DW'(m_axi_arvalid), DW'(0));
        @(posedge clk);
        #1;
        target_ar = ar_base + MO + 1;
        target_ar_cyc = -1;
        rvalid_en = 1'b1;
        for (int n = 0; n < 200 && target_ar_cyc < 0; n++) @(posedge clk);
        #1;
        checkOutput("fifth_ar_after_rlast", DW'(target_ar_cyc), DW'(first_rlast_cyc + 1));
        waitIdle("outstanding", 1500);
        checkOutput("outstanding_total_ars", DW'(ar_count - ar_base), DW'(8));
        target_ar = -1;

        // Buffer backpressure toggling every cycle.
        tready_mode = 1'b1;
        mirror_en = 1'b1;
        applyStimulus(64'h3000, 64'd4096);
        waitIdle("backpressure", 400);
        mirror_en = 1'b0;
        tready_mode = 1'b0;
        @(posedge clk);
        #1;

        // Zero-length request, then a request ignored while busy.
        ar_base = ar_count;
        done_base = done_count;
        applyStimulus(64'h40, 64'd0);
        waitIdle("zero_size", 10);
        checkOutput("zero_size_ar_count", DW'(ar_count - ar_base), DW'(0));
        checkOutput("zero_size_done_count", DW'(done_count - done_base), DW'(1));
        applyStimulus(64'h5000, 64'd4096);
        repeat (3) @(posedge clk);
        #1;
        pulseIgnored(64'h9000, 64'd64);
        waitIdle("ignored_req", 300);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("ignored_req_done_count", DW'(done_count - done_base), DW'(2));
        checkOutput("ignored_req_ar_count", DW'(ar_count - ar_base), DW'(1));

        // Error response on one beat: beat forwarded, err sticky.
        @(negedge clk);
        checkOutput("err_before", DW'(err), DW'(0));
        @(posedge clk);
        #1;
        bad_beat = slv_total + 5;
        applyStimulus(64'h0, 64'd512);
        waitIdle("bad_resp", 100);
        bad_beat = -1;
        checkOutput("err_set", DW'(err), DW'(1));
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("err_sticky", DW'(err), DW'(1));
        @(posedge clk);
        #1;

        // Reset in the middle of a burst abandons everything.
        applyStimulus(64'h8000, 64'd4096);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_busy", DW'(busy), DW'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkQuiet("mid_reset");
        flushScoreboard();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Recovery after reset: outstanding count must be back at zero.
        ar_base = ar_count;
        applyStimulus(64'h1F80, 64'd256);
        waitIdle("recovery", 100);
        checkOutput("recovery_ar_count", DW'(ar_count - ar_base), DW'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
